fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 16 +
 rtl/fetch_if_id_reg.sv | 35 +++
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_t : fetch FSM state encoding (BOOT, RUN, FAULT)
//   INSTR_W       : instruction / address datapath width
//   PC_INC        : sequential PC step in bytes
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] PC_INC = 32'd4;

endpackage

// File: rtl/fetch_if_id_reg.sv
// IF/ID holding register with valid flag.
//   clk, rst_n          : clock, asynchronous active-low reset
//   load                : capture in_data/in_pc and set valid (wins over flush)
//   flush               : clear valid without touching data/pc
//   in_data, in_pc      : fetched word and its byte address
//   out_valid, out_data, out_pc : held instruction presented to decode
module fetch_if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] in_data,
  input  logic [INSTR_W-1:0] in_pc,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_data,
  output logic [INSTR_W-1:0] out_pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_pc    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_pc    <= in_pc;
    end else if (flush) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, fetch FSM and IF/ID register.
//   RESET_PC, IMEM_BYTES : first fetch address, instruction memory size
//   clk, rst_n           : clock, asynchronous active-low reset
//   pc_out / imem_data   : instruction memory address / combinational read data
//   stall                : hold fetch (no new capture)
//   redirect_valid/_pc   : taken branch/jump target, flushes the held word
//   out_valid/out_ready  : valid/ready handshake toward decode
//   instr_out, instr_pc  : held instruction and its byte address
//   fault                : sticky misaligned/out-of-range fetch fault
//   retire_count         : number of instructions accepted by decode
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0]  RESET_PC   = 32'h0000_0000,
  parameter int unsigned  IMEM_BYTES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [INSTR_W-1:0] pc_out,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [INSTR_W-1:0] redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [INSTR_W-1:0] instr_pc,
  output logic               fault,
  output logic [31:0]        retire_count
);

  fetch_state_t       state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic               load, flush;
  logic               pc_legal, slot_free, handshake;

  assign pc_out    = pc_q;
  assign pc_legal  = (pc_q[1:0] == 2'b00) && (pc_q < INSTR_W'(IMEM_BYTES));
  assign handshake = out_valid && out_ready;
  assign slot_free = !out_valid || out_ready;
  assign fault     = (state_q == FAULT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  // Next-state logic; a redirect rescues an illegal PC before it can fault
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (!redirect_valid && !pc_legal) state_d = FAULT;
      FAULT:   state_d = FAULT;
      default: state_d = BOOT;
    endcase
  end

  // Output logic: IF/ID control and next PC
  always_comb begin
    load  = 1'b0;
    flush = 1'b0;
    pc_d  = pc_q;
    if (state_q == RUN) begin
      if (redirect_valid) begin
        flush = 1'b1;
        pc_d  = redirect_pc;
      end else if (!pc_legal) begin
        // entering FAULT drops the held word even if decode never took it
        flush = 1'b1;
      end else if (slot_free) begin
        if (!stall) begin
          load = 1'b1;
          pc_d = pc_q + PC_INC;
        end else begin
          // held word (if any) was accepted this cycle; nothing replaces it
          flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  // Counts every handshake, including one coinciding with a redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         retire_count <= '0;
    else if (handshake) retire_count <= retire_count + 32'd1;
  end

  fetch_if_id_reg u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .flush     (flush),
    .in_data   (imem_data),
    .in_pc     (pc_q),
    .out_valid (out_valid),
    .out_data  (instr_out),
    .out_pc    (instr_pc)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int unsigned IMEM = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_out, imem_data, redirect_pc, instr_out, instr_pc, retire_count;
  logic        stall, redirect_valid, out_valid, out_ready, fault;

  logic [31:0] mem [256];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_data = (pc_out < 32'(IMEM)) ? mem[pc_out[9:2]] : 32'hBAD0_BAD0;

  fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(IMEM)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_out         (pc_out),
    .imem_data      (imem_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .fault          (fault),
    .retire_count   (retire_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        stall, ready, redir;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_pc, e_ipc, e_ret;
    logic        e_fault;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic s, input logic r, input logic rd, input logic [31:0] rp,
                              input logic v, input logic [31:0] p, input logic [31:0] ip,
                              input logic [31:0] rt, input logic f);
    vec_t x;
    x.stall = s; x.ready = r; x.redir = rd; x.rpc = rp;
    x.e_valid = v; x.e_pc = p; x.e_ipc = ip; x.e_ret = rt; x.e_fault = f;
    return x;
  endfunction

  // ---------------- behavioural reference model ----------------
  logic        m_boot, m_fault, m_valid;
  logic [31:0] m_pc, m_ipc, m_ret;

  task automatic model_reset();
    m_boot = 1; m_fault = 0; m_valid = 0; m_pc = 0; m_ipc = 0; m_ret = 0;
  endtask

  // One rising edge worth of fetch behaviour, from the current inputs.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_valid && out_ready) m_ret = m_ret + 1;
    if (m_boot) m_boot = 0;
    else if (!m_fault) begin
      if (redirect_valid) begin
        m_valid = 0;
        m_pc = redirect_pc;
      end else if (m_pc % 4 != 0 || m_pc >= IMEM) begin
        m_fault = 1;
        m_valid = 0;
      end else if (!m_valid || out_ready) begin
        if (!stall) begin
          m_ipc = m_pc;
          m_valid = 1;
          m_pc = m_pc + 4;
        end else begin
          m_valid = 0;
        end
      end
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, m_valid});
    chk({tag, ".pc"}, pc_out, m_pc);
    chk({tag, ".fault"}, {31'd0, fault}, {31'd0, m_fault});
    chk({tag, ".retire"}, retire_count, m_ret);
    if (m_valid) begin
      chk({tag, ".ipc"}, instr_pc, m_ipc);
      chk({tag, ".instr"}, instr_out, mem[m_ipc[9:2]]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h00500093;
    mem[1] = 32'h00A00113;
    mem[2] = 32'h002081B3;
    mem[3] = 32'h00000013;

    vecs[0]  = mk(0, 1, 0, 32'h0,  0, 32'd0,  32'd0,  32'd0, 0);
    vecs[1]  = mk(0, 1, 0, 32'h0,  1, 32'd4,  32'd0,  32'd0, 0);
    vecs[2]  = mk(0, 1, 0, 32'h0,  1, 32'd8,  32'd4,  32'd1, 0);
    vecs[3]  = mk(0, 1, 0, 32'h0,  1, 32'd12, 32'd8,  32'd2, 0);
    vecs[4]  = mk(0, 0, 0, 32'h0,  1, 32'd12, 32'd8,  32'd2, 0);
    vecs[5]  = mk(0, 0, 0, 32'h0,  1, 32'd12, 32'd8,  32'd2, 0);
    vecs[6]  = mk(0, 0, 0, 32'h0,  1, 32'd12, 32'd8,  32'd2, 0);
    vecs[7]  = mk(0, 1, 0, 32'h0,  1, 32'd16, 32'd12, 32'd3, 0);
    vecs[8]  = mk(1, 1, 0, 32'h0,  0, 32'd16, 32'd0,  32'd4, 0);
    vecs[9]  = mk(1, 1, 0, 32'h0,  0, 32'd16, 32'd0,  32'd4, 0);
    vecs[10] = mk(0, 1, 0, 32'h0,  1, 32'd20, 32'd16, 32'd4, 0);
    vecs[11] = mk(0, 1, 0, 32'h0,  1, 32'd24, 32'd20, 32'd5, 0);
    vecs[12] = mk(1, 0, 1, 32'h40, 0, 32'h40, 32'd0,  32'd5, 0);
    vecs[13] = mk(0, 1, 0, 32'h0,  1, 32'h44, 32'h40, 32'd5, 0);
    vecs[14] = mk(0, 1, 0, 32'h0,  1, 32'h48, 32'h44, 32'd6, 0);
    vecs[15] = mk(0, 1, 1, 32'h42, 0, 32'h42, 32'd0,  32'd7, 0);
    vecs[16] = mk(0, 1, 0, 32'h0,  0, 32'h42, 32'd0,  32'd7, 1);
    vecs[17] = mk(0, 1, 1, 32'h80, 0, 32'h42, 32'd0,  32'd7, 1);

    rst_n = 0; stall = 0; out_ready = 1; redirect_valid = 0; redirect_pc = 0;
    tick(); tick();
    chk("rst.pc", pc_out, 32'h0);
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.fault", {31'd0, fault}, 32'd0);
    chk("rst.retire", retire_count, 32'd0);
    chk("rst.instr", instr_out, 32'h0);
    chk("rst.ipc", instr_pc, 32'h0);
    rst_n = 1;

    for (int i = 0; i < 18; i++) begin
      stall = vecs[i].stall; out_ready = vecs[i].ready;
      redirect_valid = vecs[i].redir; redirect_pc = vecs[i].rpc;
      tick();
      chk($sformatf("vec%0d.valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d.pc", i), pc_out, vecs[i].e_pc);
      chk($sformatf("vec%0d.retire", i), retire_count, vecs[i].e_ret);
      chk($sformatf("vec%0d.fault", i), {31'd0, fault}, {31'd0, vecs[i].e_fault});
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d.ipc", i), instr_pc, vecs[i].e_ipc);
        chk($sformatf("vec%0d.instr", i), instr_out, mem[vecs[i].e_ipc[9:2]]);
      end
    end
    stall = 0; out_ready = 1; redirect_valid = 0;

    // Reset pulse out of FAULT, checked asynchronously
    rst_n = 0;
    #1;
    chk("arst.fault", {31'd0, fault}, 32'd0);
    chk("arst.pc", pc_out, 32'h0);
    chk("arst.valid", {31'd0, out_valid}, 32'd0);
    chk("arst.retire", retire_count, 32'd0);
    tick();
    rst_n = 1;
    tick();
    chk("boot.pc", pc_out, 32'h0);
    chk("boot.valid", {31'd0, out_valid}, 32'd0);

    // Sequential fetch running off the end of memory, last word not accepted
    redirect_valid = 1; redirect_pc = 32'(IMEM - 8);
    tick();
    redirect_valid = 0;
    chk("end.redir_pc", pc_out, 32'(IMEM - 8));
    tick();
    chk("end.ipc0", instr_pc, 32'(IMEM - 8));
    tick();
    chk("end.ipc1", instr_pc, 32'(IMEM - 4));
    chk("end.pc_top", pc_out, 32'(IMEM));
    chk("end.valid1", {31'd0, out_valid}, 32'd1);
    out_ready = 0;
    tick();
    chk("end.fault", {31'd0, fault}, 32'd1);
    chk("end.dropped", {31'd0, out_valid}, 32'd0);
    chk("end.pc_frozen", pc_out, 32'(IMEM));
    chk("end.retire", retire_count, 32'd1);
    out_ready = 1; redirect_valid = 1; redirect_pc = 32'h10; stall = 1;
    tick();
    redirect_valid = 0; stall = 0;
    chk("end.redir_ignored", pc_out, 32'(IMEM));
    chk("end.fault_sticky", {31'd0, fault}, 32'd1);

    // Randomized run against the reference model
    rst_n = 0;
    tick();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      logic do_rst;
      stall = ($urandom_range(0, 99) < 25);
      out_ready = ($urandom_range(0, 99) < 70);
      redirect_valid = ($urandom_range(0, 99) < 6);
      begin
        int unsigned r;
        r = $urandom_range(0, 99);
        if (r < 88)      redirect_pc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        else if (r < 94) redirect_pc = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        else             redirect_pc = 32'(IMEM) + {24'd0, 6'($urandom), 2'b00};
      end
      do_rst = ($urandom_range(0, 199) == 0) || (m_fault && $urandom_range(0, 9) == 0);
      rst_n = !do_rst;
      if (do_rst) begin
        #1;
        chk("rnd.arst_pc", pc_out, 32'h0);
        chk("rnd.arst_valid", {31'd0, out_valid}, 32'd0);
        model_reset();
      end
      model_edge();
      tick();
      compare_model("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
